// File: rtl/ext_btn_cntr_axil_slave.sv
// ext_btn_cntr_axil_slave
// AXI4-Lite slave for the external button counter IP. The raw push-button
// input is synchronized, debounced and edge-detected; qualified edges
// increment a 32-bit counter that is compared against a programmable
// threshold to raise a sticky HIT flag and a level interrupt.
//
// Register map (byte offsets, decoded on addr[3:2]):
//   0x0 CTRL   : bit0 EN, bit1 CLR (self-clearing), bit2 IRQ_EN, bit3 EDGE_SEL
//   0x4 THRESH : 32-bit threshold
//   0x8 COUNT  : live count, writable (strobed bytes)
//   0xC STATUS : bit0 HIT (sticky, W1C), bit1 debounced button level (RO)
//
// Ports:
//   ACLK, ARESETN   : clock, synchronous active-low reset
//   btn_in          : raw asynchronous push-button
//   s_axi_aw*/w*/b* : AXI4-Lite write address / data / response channels
//   s_axi_ar*/r*    : AXI4-Lite read address / data channels
//   irq             : registered level interrupt (HIT & IRQ_EN)

module ext_btn_cntr_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int DEBOUNCE_CYCLES    = 100000
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic                            btn_in,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic                            irq
);

    localparam int DW   = C_S_AXI_DATA_WIDTH;
    localparam int SW   = DW / 8;
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_THRESH = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    logic            awready_q, awready_d;
    logic            bvalid_q, bvalid_d;
    logic            arready_q, arready_d;
    logic            rvalid_q, rvalid_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic [3:0]      ctrl_q, ctrl_d;
    logic [DW-1:0]   thresh_q, thresh_d;
    logic [DW-1:0]   count_q, count_d;
    logic            hit_q, hit_d;
    logic            irq_q;

    logic            sync1_q, sync2_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            db_level_q, db_level_d;
    logic            db_toggle;
    logic            edge_q, edge_d;

    logic            wr_en, rd_en;
    logic [1:0]      wr_sel, rd_sel;
    logic [DW-1:0]   wmask;
    logic [DW-1:0]   count_inc;
    logic            clr_wr, cnt_wr, hit_w1c;
    logic            unused_ok;

    assign unused_ok = ^{s_axi_awprot, s_axi_arprot,
                         s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Handshake completes on the edge where the one-cycle ready pulse is seen
    // together with the (still held) valids.
    assign wr_en  = awready_q & s_axi_awvalid & s_axi_wvalid;
    assign rd_en  = arready_q & s_axi_arvalid;
    assign wr_sel = s_axi_awaddr[3:2];
    assign rd_sel = s_axi_araddr[3:2];

    assign clr_wr  = wr_en && (wr_sel == REG_CTRL) && s_axi_wstrb[0] && s_axi_wdata[1];
    assign cnt_wr  = wr_en && (wr_sel == REG_COUNT);
    assign hit_w1c = wr_en && (wr_sel == REG_STATUS) && s_axi_wstrb[0] && s_axi_wdata[0];

    always_comb begin
        wmask = '0;
        for (int i = 0; i < SW; i++) begin
            wmask[8*i +: 8] = {8{s_axi_wstrb[i]}};
        end
    end

    always_comb begin
        awready_d = s_axi_awvalid & s_axi_wvalid & ~bvalid_q & ~awready_q;
        arready_d = s_axi_arvalid & ~rvalid_q & ~arready_q;

        bvalid_d = bvalid_q;
        if (bvalid_q && s_axi_bready) bvalid_d = 1'b0;
        if (wr_en)                    bvalid_d = 1'b1;

        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (rvalid_q && s_axi_rready) rvalid_d = 1'b0;
        if (rd_en) begin
            rvalid_d = 1'b1;
            unique case (rd_sel)
                REG_CTRL:   rdata_d = {{(DW-4){1'b0}}, ctrl_q};
                REG_THRESH: rdata_d = thresh_q;
                REG_COUNT:  rdata_d = count_q;
                default:    rdata_d = {{(DW-2){1'b0}}, db_level_q, hit_q};
            endcase
        end
    end

    // The debounce counter only runs while the synchronized input disagrees
    // with the accepted level, so any bounce back restarts the qualification.
    always_comb begin
        db_cnt_d   = '0;
        db_level_d = db_level_q;
        db_toggle  = 1'b0;
        if (sync2_q != db_level_q) begin
            if (db_cnt_q == DB_MAX) begin
                db_toggle  = 1'b1;
                db_level_d = ~db_level_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
        // EDGE_SEL=0 selects the 0->1 transition, EDGE_SEL=1 the 1->0 one.
        edge_d = db_toggle & (db_level_d == ~ctrl_q[3]);
    end

    // CLR beats a COUNT load, which beats an increment; an edge arriving with
    // either write is deliberately lost. A HIT set wins over a same-cycle W1C.
    always_comb begin
        ctrl_d    = ctrl_q;
        thresh_d  = thresh_q;
        count_d   = count_q;
        hit_d     = hit_q;
        count_inc = count_q + DW'(1);

        if (wr_en && (wr_sel == REG_CTRL) && s_axi_wstrb[0]) begin
            ctrl_d = {s_axi_wdata[3], s_axi_wdata[2], 1'b0, s_axi_wdata[0]};
        end
        if (wr_en && (wr_sel == REG_THRESH)) begin
            thresh_d = (thresh_q & ~wmask) | (s_axi_wdata & wmask);
        end
        if (hit_w1c) hit_d = 1'b0;

        if (clr_wr) begin
            count_d = '0;
            hit_d   = 1'b0;
        end else if (cnt_wr) begin
            count_d = (count_q & ~wmask) | (s_axi_wdata & wmask);
        end else if (edge_q && ctrl_q[0]) begin
            count_d = count_inc;
            if ((count_inc == thresh_q) && (thresh_q != '0)) hit_d = 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            awready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            ctrl_q     <= '0;
            thresh_q   <= '0;
            count_q    <= '0;
            hit_q      <= 1'b0;
            irq_q      <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_cnt_q   <= '0;
            db_level_q <= 1'b0;
            edge_q     <= 1'b0;
        end else begin
            awready_q  <= awready_d;
            bvalid_q   <= bvalid_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            ctrl_q     <= ctrl_d;
            thresh_q   <= thresh_d;
            count_q    <= count_d;
            hit_q      <= hit_d;
            irq_q      <= hit_q & ctrl_q[2];
            sync1_q    <= btn_in;
            sync2_q    <= sync1_q;
            db_cnt_q   <= db_cnt_d;
            db_level_q <= db_level_d;
            edge_q     <= edge_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = awready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;
    assign irq           = irq_q;

endmodule

// File: tb/tb_ext_btn_cntr_axil_slave.sv
// tb_ext_btn_cntr_axil_slave
// Directed self-checking bench for ext_btn_cntr_axil_slave with a short
// debounce window (4 cycles). Each scenario task drives its own stimulus and
// compares against hand-computed values.

module tb_ext_btn_cntr_axil_slave;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        btn_in;
    logic [3:0]  s_axi_awaddr;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [3:0]  s_axi_araddr;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic        irq;

    int n_compared = 0;
    int n_mismatch = 0;

    always #5 ACLK = ~ACLK;

    ext_btn_cntr_axil_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4),
        .DEBOUNCE_CYCLES   (4)
    ) dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .btn_in       (btn_in),
        .s_axi_awaddr (s_axi_awaddr),
        .s_axi_awprot (s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata  (s_axi_wdata),
        .s_axi_wstrb  (s_axi_wstrb),
        .s_axi_wvalid (s_axi_wvalid),
        .s_axi_wready (s_axi_wready),
        .s_axi_bresp  (s_axi_bresp),
        .s_axi_bvalid (s_axi_bvalid),
        .s_axi_bready (s_axi_bready),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arprot (s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .irq          (irq)
    );

    // Advance n cycles and land 1 ns after the rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        int n;
        resp = 2'b11;
        s_axi_awaddr  = a;
        s_axi_wdata   = d;
        s_axi_wstrb   = s;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        n = 0;
        while (s_axi_awready !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        if (n >= 20) begin
            n_compared++;
            n_mismatch++;
            $display("[TB] FAIL write_aw_timeout: awready got 0, expected 1 (addr 0x%h)", a);
            s_axi_awvalid = 1'b0;
            s_axi_wvalid  = 1'b0;
            return;
        end
        tick(1);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        n = 0;
        while (s_axi_bvalid !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        if (n >= 20) begin
            n_compared++;
            n_mismatch++;
            $display("[TB] FAIL write_b_timeout: bvalid got 0, expected 1 (addr 0x%h)", a);
            return;
        end
        resp = s_axi_bresp;
        s_axi_bready = 1'b1;
        tick(1);
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d,
                            output logic [1:0] resp);
        int n;
        d    = 32'hDEAD_BEEF;
        resp = 2'b11;
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        n = 0;
        while (s_axi_arready !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        if (n >= 20) begin
            n_compared++;
            n_mismatch++;
            $display("[TB] FAIL read_ar_timeout: arready got 0, expected 1 (addr 0x%h)", a);
            s_axi_arvalid = 1'b0;
            return;
        end
        tick(1);
        s_axi_arvalid = 1'b0;
        n = 0;
        while (s_axi_rvalid !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        if (n >= 20) begin
            n_compared++;
            n_mismatch++;
            $display("[TB] FAIL read_r_timeout: rvalid got 0, expected 1 (addr 0x%h)", a);
            return;
        end
        d    = s_axi_rdata;
        resp = s_axi_rresp;
        s_axi_rready = 1'b1;
        tick(1);
        s_axi_rready = 1'b0;
    endtask

    // One clean press: high for 10 cycles, then low for 10 cycles.
    task automatic press();
        btn_in = 1'b1;
        tick(10);
        btn_in = 1'b0;
        tick(10);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        ARESETN = 1'b0;
        tick(3);
        n_compared++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, irq} !== 6'b0) begin
            n_mismatch++;
            $display("[TB] FAIL reset_handshake: got %b, expected 000000",
                     {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, irq});
        end
        n_compared++;
        if (s_axi_rdata !== 32'h0) begin
            n_mismatch++;
            $display("[TB] FAIL reset_rdata: got 0x%h, expected 0x0", s_axi_rdata);
        end
        ARESETN = 1'b1;
        tick(2);
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), d, r);
            n_compared++;
            if (d !== 32'h0) begin
                n_mismatch++;
                $display("[TB] FAIL reset_reg%0d: got 0x%h, expected 0x0", i, d);
            end
        end
    endtask

    task automatic test_regmap();
        logic [31:0] d;
        logic [1:0]  r;
        logic [31:0] exp_rd [4];
        exp_rd = '{32'h1, 32'h2, 32'h3, 32'h0};
        for (int i = 0; i < 4; i++) begin
            axi_write(4'(i * 4), 32'(i + 1), 4'hF, r);
            n_compared++;
            if (r !== 2'b00) begin
                n_mismatch++;
                $display("[TB] FAIL regmap_bresp%0d: got %b, expected 00", i, r);
            end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), d, r);
            n_compared++;
            if (d !== exp_rd[i] || r !== 2'b00) begin
                n_mismatch++;
                $display("[TB] FAIL regmap_read%0d: got 0x%h resp %b, expected 0x%h resp 00",
                         i, d, r, exp_rd[i]);
            end
        end
        // Byte strobes on THRESH: bytes 0 and 2 only.
        axi_write(4'h4, 32'hAABB_CCDD, 4'b0101, r);
        axi_read(4'h4, d, r);
        n_compared++;
        if (d !== 32'h00BB_00DD) begin
            n_mismatch++;
            $display("[TB] FAIL regmap_wstrb: got 0x%h, expected 0x00bb00dd", d);
        end
        // All CTRL bits set: CLR clears COUNT and reads back as 0.
        axi_write(4'h0, 32'hFFFF_FFFF, 4'hF, r);
        axi_read(4'h0, d, r);
        n_compared++;
        if (d !== 32'hD) begin
            n_mismatch++;
            $display("[TB] FAIL regmap_ctrl_rb: got 0x%h, expected 0xd", d);
        end
        axi_read(4'h8, d, r);
        n_compared++;
        if (d !== 32'h0) begin
            n_mismatch++;
            $display("[TB] FAIL regmap_clr_count: got 0x%h, expected 0x0", d);
        end
    endtask

    task automatic test_count_press();
        logic [31:0] d;
        logic [1:0]  r;
        int n;
        axi_write(4'h0, 32'h2, 4'hF, r);
        axi_write(4'h0, 32'h1, 4'hF, r);
        axi_write(4'h4, 32'h3, 4'hF, r);
        repeat (3) press();
        axi_read(4'h8, d, r);
        n_compared++;
        if (d !== 32'h3) begin
            n_mismatch++;
            $display("[TB] FAIL press_count: got 0x%h, expected 0x3", d);
        end
        axi_read(4'hC, d, r);
        n_compared++;
        if (d !== 32'h1) begin
            n_mismatch++;
            $display("[TB] FAIL press_status: got 0x%h, expected 0x1", d);
        end
        n_compared++;
        if (irq !== 1'b0) begin
            n_mismatch++;
            $display("[TB] FAIL press_irq_off: got %b, expected 0", irq);
        end
        // CTRL=0x5 written by hand to observe irq timing around the handshake.
        s_axi_awaddr  = 4'h0;
        s_axi_wdata   = 32'h5;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        n = 0;
        while (s_axi_awready !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        tick(1);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        n_compared++;
        if (s_axi_bvalid !== 1'b1 || irq !== 1'b0) begin
            n_mismatch++;
            $display("[TB] FAIL irq_edge_before: bvalid/irq got %b%b, expected 10", s_axi_bvalid, irq);
        end
        s_axi_bready = 1'b1;
        tick(1);
        s_axi_bready = 1'b0;
        n_compared++;
        if (irq !== 1'b1) begin
            n_mismatch++;
            $display("[TB] FAIL irq_edge_after: got %b, expected 1", irq);
        end
        // W1C on HIT drops the interrupt.
        axi_write(4'hC, 32'h1, 4'hF, r);
        tick(2);
        n_compared++;
        if (irq !== 1'b0) begin
            n_mismatch++;
            $display("[TB] FAIL w1c_irq: got %b, expected 0", irq);
        end
        axi_read(4'hC, d, r);
        n_compared++;
        if (d !== 32'h0) begin
            n_mismatch++;
            $display("[TB] FAIL w1c_status: got 0x%h, expected 0x0", d);
        end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(4'h0, 32'h2, 4'hF, r);
        axi_write(4'h0, 32'h1, 4'hF, r);
        btn_in = 1'b1;
        tick(2);
        btn_in = 1'b0;
        axi_read(4'hC, d, r);
        n_compared++;
        if (d !== 32'h0) begin
            n_mismatch++;
            $display("[TB] FAIL glitch_status_early: got 0x%h, expected 0x0", d);
        end
        tick(10);
        axi_read(4'hC, d, r);
        n_compared++;
        if (d !== 32'h0) begin
            n_mismatch++;
            $display("[TB] FAIL glitch_status_late: got 0x%h, expected 0x0", d);
        end
        axi_read(4'h8, d, r);
        n_compared++;
        if (d !== 32'h0) begin
            n_mismatch++;
            $display("[TB] FAIL glitch_count: got 0x%h, expected 0x0", d);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(4'h8, 32'hFFFF_FFFF, 4'hF, r);
        press();
        axi_read(4'h8, d, r);
        n_compared++;
        if (d !== 32'h0) begin
            n_mismatch++;
            $display("[TB] FAIL wrap_count: got 0x%h, expected 0x0", d);
        end
        axi_read(4'hC, d, r);
        n_compared++;
        if (d !== 32'h0) begin
            n_mismatch++;
            $display("[TB] FAIL wrap_hit: got 0x%h, expected 0x0", d);
        end
    endtask

    task automatic test_handshake();
        logic [31:0] d;
        logic [1:0]  r;
        logic        bad;
        int n;
        // Lone W then lone AW must both be left waiting.
        bad = 1'b0;
        s_axi_awaddr = 4'h4;
        s_axi_wdata  = 32'h55;
        s_axi_wstrb  = 4'hF;
        s_axi_wvalid = 1'b1;
        repeat (5) begin
            tick(1);
            if (s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0) bad = 1'b1;
        end
        s_axi_wvalid  = 1'b0;
        s_axi_awvalid = 1'b1;
        repeat (5) begin
            tick(1);
            if (s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0) bad = 1'b1;
        end
        n_compared++;
        if (bad !== 1'b0) begin
            n_mismatch++;
            $display("[TB] FAIL lone_channel: ready seen %b, expected 0", bad);
        end
        s_axi_awvalid = 1'b0;
        axi_write(4'h4, 32'h55, 4'hF, r);
        axi_read(4'h4, d, r);
        n_compared++;
        if (d !== 32'h55) begin
            n_mismatch++;
            $display("[TB] FAIL late_w_write: got 0x%h, expected 0x55", d);
        end
        // bready held low while a second write is already presented.
        s_axi_wdata   = 32'h66;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        n = 0;
        while (s_axi_awready !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        tick(1);
        s_axi_wdata = 32'h77;
        bad = 1'b0;
        repeat (6) begin
            if (s_axi_bvalid !== 1'b1 || s_axi_awready !== 1'b0) bad = 1'b1;
            tick(1);
        end
        n_compared++;
        if (bad !== 1'b0) begin
            n_mismatch++;
            $display("[TB] FAIL bready_hold: violation seen %b, expected 0", bad);
        end
        s_axi_bready = 1'b1;
        tick(1);
        s_axi_bready = 1'b0;
        n_compared++;
        if (s_axi_bvalid !== 1'b0) begin
            n_mismatch++;
            $display("[TB] FAIL bvalid_drop: got %b, expected 0", s_axi_bvalid);
        end
        axi_write(4'h4, 32'h77, 4'hF, r);
        axi_read(4'h4, d, r);
        n_compared++;
        if (d !== 32'h77) begin
            n_mismatch++;
            $display("[TB] FAIL second_write: got 0x%h, expected 0x77", d);
        end
        // rready held low while COUNT changes underneath.
        axi_write(4'h8, 32'hA5A5_0001, 4'hF, r);
        s_axi_araddr  = 4'h8;
        s_axi_arvalid = 1'b1;
        n = 0;
        while (s_axi_arready !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        tick(1);
        s_axi_arvalid = 1'b0;
        axi_write(4'h8, 32'h1234_5678, 4'hF, r);
        tick(3);
        n_compared++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'hA5A5_0001) begin
            n_mismatch++;
            $display("[TB] FAIL rready_hold: rvalid %b rdata 0x%h, expected 1 0xa5a50001",
                     s_axi_rvalid, s_axi_rdata);
        end
        s_axi_rready = 1'b1;
        tick(1);
        s_axi_rready = 1'b0;
        axi_read(4'h8, d, r);
        n_compared++;
        if (d !== 32'h1234_5678) begin
            n_mismatch++;
            $display("[TB] FAIL count_after_hold: got 0x%h, expected 0x12345678", d);
        end
    endtask

    task automatic test_edge_collision();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(4'h0, 32'h1, 4'hF, r);
        axi_write(4'h8, 32'h5, 4'hF, r);
        // Edge pulse is present in the cycle before the 7th edge after the
        // press; the COUNT write handshake is timed to land on that edge.
        btn_in = 1'b1;
        tick(5);
        axi_write(4'h8, 32'h10, 4'hF, r);
        tick(6);
        btn_in = 1'b0;
        tick(10);
        axi_read(4'h8, d, r);
        n_compared++;
        if (d !== 32'h10) begin
            n_mismatch++;
            $display("[TB] FAIL edge_collision: got 0x%h, expected 0x10", d);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] d;
        logic [1:0]  r;
        int n;
        axi_write(4'h0, 32'h5, 4'hF, r);
        axi_write(4'h4, 32'h1, 4'hF, r);
        axi_write(4'h8, 32'h0, 4'hF, r);
        press();
        n_compared++;
        if (irq !== 1'b1) begin
            n_mismatch++;
            $display("[TB] FAIL pre_reset_irq: got %b, expected 1", irq);
        end
        s_axi_araddr  = 4'hC;
        s_axi_arvalid = 1'b1;
        n = 0;
        while (s_axi_arready !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        tick(1);
        s_axi_arvalid = 1'b0;
        ARESETN = 1'b0;
        tick(1);
        n_compared++;
        if (s_axi_rvalid !== 1'b0 || irq !== 1'b0 || s_axi_rdata !== 32'h0) begin
            n_mismatch++;
            $display("[TB] FAIL mid_read_reset: rvalid %b irq %b rdata 0x%h, expected 0 0 0x0",
                     s_axi_rvalid, irq, s_axi_rdata);
        end
        ARESETN = 1'b1;
        tick(3);
        n_compared++;
        if (s_axi_rvalid !== 1'b0) begin
            n_mismatch++;
            $display("[TB] FAIL stale_response: rvalid got %b, expected 0", s_axi_rvalid);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), d, r);
            n_compared++;
            if (d !== 32'h0) begin
                n_mismatch++;
                $display("[TB] FAIL post_reset_reg%0d: got 0x%h, expected 0x0", i, d);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ARESETN       = 1'b0;
        btn_in        = 1'b0;
        s_axi_awaddr  = '0;
        s_axi_awprot  = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_araddr  = '0;
        s_axi_arprot  = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        tick(1);

        test_reset();
        test_regmap();
        test_count_press();
        test_glitch();
        test_wrap();
        test_handshake();
        test_edge_collision();
        test_reset_mid_read();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
